nfu_mac_array: RTL and testbench

Pipelined, multi-lane signed fixed-point multiply-accumulate unit. It is the parametrised successor of the single combinational multiply-add neuron. Each of LANES lanes computes nbin*sb, rescales it, and accumulates over a multi-beat window. The window is seeded from a partial sum (nbout) on its first beat. Each window produces one saturated N-bit result per lane, with valid/ready handshakes on both sides. It sits between the NBin/SB buffer readers and the NBout writeback.

---
 rtl/nfu_pkg.sv | 39 +++
 rtl/nfu_mac_lane.sv | 72 +++++++
 rtl/nfu_mac_array.sv | 78 +++++++
 tb/tb_nfu_mac_array.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfu_pkg.sv
// Shared defaults and helpers for the NFU multiply-accumulate array.
// Lanes and the top import this package for widths, saturation and bus slicing.
package nfu_pkg;

   localparam int N_DEF     = 16;
   localparam int LANES_DEF = 16;
   localparam int FRAC_DEF  = 8;
   localparam int ACC_W_DEF = 36;
   localparam int SAT_IN_W  = 64;

   typedef struct packed {
      logic                ovf;
      logic [SAT_IN_W-1:0] val;
   } sat_t;

   // Clamp a sign-extended sum into the n-bit signed range; the result sits in val[n-1:0].
   function automatic sat_t sat_n(input logic signed [SAT_IN_W-1:0] sum, input int n);
      logic signed [SAT_IN_W-1:0] max_v;
      logic signed [SAT_IN_W-1:0] min_v;
      sat_t                       r;
      max_v = (64'sd1 <<< (n - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (n - 1));
      r.ovf = 1'b0;
      r.val = sum;
      if (sum > max_v) begin
         r.ovf = 1'b1;
         r.val = max_v;
      end else if (sum < min_v) begin
         r.ovf = 1'b1;
         r.val = min_v;
      end
      return r;
   endfunction

   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/nfu_mac_lane.sv
// One MAC lane: registered rescaled product, window accumulator and saturated result.
// Handshake and stage control come from the array top.
module nfu_mac_lane
   import nfu_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         accept,
   input  logic         in_first,
   input  logic         adv,
   input  logic         s1_first,
   input  logic         s1_last,
   input  logic [N-1:0] nbin,
   input  logic [N-1:0] sb,
   input  logic [N-1:0] nbout,
   output logic [N-1:0] res,
   output logic         ovf
);

   localparam int PROD_W = 2 * N;
   localparam int SC_W   = PROD_W - FRAC;

   logic signed [PROD_W-1:0] prod;
   logic signed [SC_W-1:0]   sc_next;
   logic signed [SC_W-1:0]   sc_reg;
   logic signed [N-1:0]      nbout_reg;
   logic signed [ACC_W-1:0]  acc_reg;
   logic signed [ACC_W-1:0]  base;
   logic signed [ACC_W-1:0]  sum;
   sat_t                     sat;
   logic                     sat_unused;

   assign prod    = PROD_W'($signed(nbin)) * PROD_W'($signed(sb));
   assign sc_next = SC_W'(prod >>> FRAC);

   assign base = s1_first ? ACC_W'(nbout_reg) : acc_reg;
   assign sum  = base + ACC_W'(sc_reg);
   assign sat  = sat_n(SAT_IN_W'(sum), N);
   assign sat_unused = ^sat.val[SAT_IN_W-1:N];

   // The seed is captured only on opening beats so a floating nbout never enters the datapath.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sc_reg    <= '0;
         nbout_reg <= '0;
         acc_reg   <= '0;
         res       <= '0;
         ovf       <= 1'b0;
      end else begin
         if (accept) begin
            sc_reg <= sc_next;
         end
         if (accept && in_first) begin
            nbout_reg <= nbout;
         end
         if (adv) begin
            if (s1_last) begin
               acc_reg <= '0;
               res     <= sat.val[N-1:0];
               ovf     <= sat.ovf;
            end else begin
               acc_reg <= sum;
            end
         end
      end
   end

endmodule

// File: rtl/nfu_mac_array.sv
// Multi-lane pipelined fixed-point MAC: accept stage, accumulate stage, held result.
// A pending result that downstream refuses freezes the whole pipeline.
module nfu_mac_array
   import nfu_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int LANES = LANES_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic               i_first,
   input  logic               i_last,
   input  logic [LANES*N-1:0] i_nbin,
   input  logic [LANES*N-1:0] i_sb,
   input  logic [LANES*N-1:0] i_nbout,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [LANES*N-1:0] o_res,
   output logic [LANES-1:0]   o_ovf
);

   logic stall;
   logic accept;
   logic adv;
   logic s1_valid_reg;
   logic s1_first_reg;
   logic s1_last_reg;

   assign stall   = o_valid & ~i_ready;
   assign o_ready = ~stall;
   assign accept  = i_valid & o_ready;
   assign adv     = s1_valid_reg & ~stall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_first_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         o_valid      <= 1'b0;
      end else if (!stall) begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_first_reg <= i_first;
            s1_last_reg  <= i_last;
         end
         // Unstalled with o_valid high implies i_ready, so the old result is consumed here.
         o_valid <= s1_valid_reg & s1_last_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         nfu_mac_lane #(
            .N     (N),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
         ) u_lane (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .accept   (accept),
            .in_first (i_first),
            .adv      (adv),
            .s1_first (s1_first_reg),
            .s1_last  (s1_last_reg),
            .nbin     (i_nbin[lane_lsb(gi, N) +: N]),
            .sb       (i_sb[lane_lsb(gi, N) +: N]),
            .nbout    (i_nbout[lane_lsb(gi, N) +: N]),
            .res      (o_res[lane_lsb(gi, N) +: N]),
            .ovf      (o_ovf[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_nfu_mac_array.sv
// Directed plus randomized bench for nfu_mac_array against a per-lane integer reference model.
`timescale 1ns/1ps
module tb_nfu_mac_array;
   import nfu_pkg::*;

   localparam int N     = N_DEF;
   localparam int LANES = LANES_DEF;
   localparam int FRAC  = FRAC_DEF;
   localparam int ACC_W = ACC_W_DEF;
   localparam int BW    = N * LANES;

   typedef logic [BW-1:0] bus_t;
   typedef struct {
      bus_t             res;
      logic [LANES-1:0] ovf;
   } exp_t;

   logic             i_clk;
   logic             i_rst_n;
   logic             i_valid;
   logic             o_ready;
   logic             i_first;
   logic             i_last;
   bus_t             i_nbin;
   bus_t             i_sb;
   bus_t             i_nbout;
   logic             o_valid;
   logic             i_ready;
   bus_t             o_res;
   logic [LANES-1:0] o_ovf;

   nfu_mac_array #(.N(N), .LANES(LANES), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_first (i_first),
      .i_last  (i_last),
      .i_nbin  (i_nbin),
      .i_sb    (i_sb),
      .i_nbout (i_nbout),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_ovf   (o_ovf)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;
   int n_results = 0;
   int n_expected = 0;
   bit done_snd;

   logic [N-1:0] nbin_v [LANES];
   logic [N-1:0] sb_v [LANES];
   logic [N-1:0] nbout_v [LANES];
   longint       acc_m [LANES];
   exp_t         exp_q [$];
   exp_t         got_e;
   bus_t         held_res;

   task automatic chk(input string tag, input bus_t got, input bus_t want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, want);
      end
   endtask

   function automatic bus_t rep(input logic [N-1:0] v);
      bus_t b;
      for (int k = 0; k < LANES; k++) b[k*N +: N] = v;
      return b;
   endfunction

   function automatic void fill(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
      for (int k = 0; k < LANES; k++) begin
         nbin_v[k]  = a;
         sb_v[k]    = b;
         nbout_v[k] = c;
      end
   endfunction

   function automatic void rnd();
      for (int k = 0; k < LANES; k++) begin
         nbin_v[k]  = N'($urandom);
         sb_v[k]    = N'($urandom);
         nbout_v[k] = N'($urandom);
      end
   endfunction

   // Reference: signed product floored by 2^FRAC, window sum, clamp to N-bit signed range.
   function automatic void model_beat(input bit first, input bit last);
      exp_t   e;
      longint p, sc, sum, maxv, minv;
      logic [N-1:0] v;
      e.res = '0;
      e.ovf = '0;
      maxv = (longint'(1) << (N - 1)) - 1;
      minv = -(longint'(1) << (N - 1));
      for (int k = 0; k < LANES; k++) begin
         p   = longint'($signed(nbin_v[k])) * longint'($signed(sb_v[k]));
         sc  = p >>> FRAC;
         sum = (first ? longint'($signed(nbout_v[k])) : acc_m[k]) + sc;
         if (last) begin
            if (sum > maxv) begin
               v = N'(maxv);
               e.ovf[k] = 1'b1;
            end else if (sum < minv) begin
               v = N'(minv);
               e.ovf[k] = 1'b1;
            end else begin
               v = sum[N-1:0];
            end
            e.res[k*N +: N] = v;
            acc_m[k] = 0;
         end else begin
            acc_m[k] = sum;
         end
      end
      if (last) begin
         exp_q.push_back(e);
         n_expected++;
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      for (int k = 0; k < LANES; k++) acc_m[k] = 0;
   endfunction

   // Called just after a posedge; returns just after the posedge that accepted the beat.
   task automatic drive_beat(input bit first, input bit last);
      bit ok;
      int waits = 0;
      for (int k = 0; k < LANES; k++) begin
         i_nbin[k*N +: N]  = nbin_v[k];
         i_sb[k*N +: N]    = sb_v[k];
         i_nbout[k*N +: N] = nbout_v[k];
      end
      i_first = first;
      i_last  = last;
      i_valid = 1'b1;
      forever begin
         @(negedge i_clk);
         ok = o_ready;
         @(posedge i_clk);
         #1;
         if (ok) break;
         waits++;
         if (waits > 60) begin
            $display("FAIL accept_timeout got=o_ready_low exp=accept");
            $fatal(1, "accept timeout");
         end
      end
      model_beat(first, last);
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   always @(negedge i_clk) begin
      if (i_rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_result", bus_t'(o_valid), '0);
         end else begin
            got_e = exp_q.pop_front();
            chk("result_res", o_res, got_e.res);
            chk("result_ovf", bus_t'(o_ovf), bus_t'(got_e.ovf));
            n_results++;
            $display("result %0d res=%h ovf=%h", n_results, o_res, o_ovf);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_first = 1'b0;
      i_last  = 1'b0;
      i_nbin  = '0;
      i_sb    = '0;
      i_nbout = '0;
      i_ready = 1'b1;
      done_snd = 1'b0;
      model_reset();
      idle(3);
      chk("rst_valid", bus_t'(o_valid), '0);
      chk("rst_res", o_res, '0);
      chk("rst_ovf", bus_t'(o_ovf), '0);
      chk("rst_ready", bus_t'(o_ready), bus_t'(1));
      i_rst_n = 1'b1;
      idle(1);

      // Single-beat window with exact two-cycle latency
      fill(16'h0200, 16'h0180, 16'h0100);
      drive_beat(1'b1, 1'b1);
      @(negedge i_clk);
      chk("t1_valid_c1", bus_t'(o_valid), '0);
      @(negedge i_clk);
      chk("t1_valid_c2", bus_t'(o_valid), bus_t'(1));
      chk("t1_res", o_res, rep(16'h0400));
      chk("t1_ovf", bus_t'(o_ovf), '0);
      idle(2);

      // Three-beat window; nbout on non-first beats must be ignored
      fill(16'h0100, 16'h0100, 16'h0000);
      drive_beat(1'b1, 1'b0);
      @(negedge i_clk);
      chk("t2_valid_b1", bus_t'(o_valid), '0);
      idle(1);
      fill(16'h0100, 16'h0100, 16'h7777);
      drive_beat(1'b0, 1'b0);
      @(negedge i_clk);
      chk("t2_valid_b2", bus_t'(o_valid), '0);
      idle(1);
      drive_beat(1'b0, 1'b1);
      @(negedge i_clk);
      chk("t2_valid_b3", bus_t'(o_valid), '0);
      @(negedge i_clk);
      chk("t2_res", o_res, rep(16'h0300));
      idle(2);

      // Saturation high, saturation low, floor rounding of a small negative product
      fill(16'h7FFF, 16'h7FFF, 16'h0000);
      drive_beat(1'b1, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t3_pos_res", o_res, rep(16'h7FFF));
      chk("t3_pos_ovf", bus_t'(o_ovf), bus_t'({LANES{1'b1}}));
      idle(1);
      fill(16'h8000, 16'h7FFF, 16'h0000);
      drive_beat(1'b1, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t3_neg_res", o_res, rep(16'h8000));
      chk("t3_neg_ovf", bus_t'(o_ovf), bus_t'({LANES{1'b1}}));
      idle(1);
      fill(16'hFFFF, 16'h0080, 16'h0000);
      drive_beat(1'b1, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t4_floor_res", o_res, rep(16'hFFFF));
      chk("t4_floor_ovf", bus_t'(o_ovf), '0);
      idle(2);

      // Backpressure: four single-beat windows while downstream refuses
      i_ready = 1'b0;
      fork
         begin
            for (int b = 0; b < 4; b++) begin
               rnd();
               drive_beat(1'b1, 1'b1);
            end
         end
         begin
            for (int w = 0; w < 20 && !o_valid; w++) @(negedge i_clk);
            chk("t5_valid_held", bus_t'(o_valid), bus_t'(1));
            held_res = o_res;
            repeat (5) begin
               @(negedge i_clk);
               chk("t5_ready_low", bus_t'(o_ready), '0);
               chk("t5_res_stable", o_res, held_res);
            end
            @(posedge i_clk);
            #1;
            i_ready = 1'b1;
         end
      join
      idle(8);
      chk("t5_count", bus_t'(n_results), bus_t'(n_expected));
      chk("t5_queue_empty", bus_t'(exp_q.size()), '0);

      // Randomized windows with input gaps and random downstream backpressure
      fork
         begin
            for (int w = 0; w < 30; w++) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  bit f;
                  rnd();
                  f = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                  drive_beat(f, b == len - 1);
                  if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
               end
            end
            done_snd = 1'b1;
         end
         begin
            while (!done_snd) begin
               i_ready = ($urandom_range(0, 2) != 0);
               @(posedge i_clk);
               #1;
            end
            i_ready = 1'b1;
         end
      join
      idle(8);
      chk("rand_count", bus_t'(n_results), bus_t'(n_expected));
      chk("rand_queue_empty", bus_t'(exp_q.size()), '0);

      // Asynchronous reset with a window open
      fill(16'h0100, 16'h0100, 16'h0000);
      drive_beat(1'b1, 1'b0);
      drive_beat(1'b0, 1'b0);
      idle(2);
      #2;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_rst_valid", bus_t'(o_valid), '0);
      chk("t6_rst_res", o_res, '0);
      chk("t6_rst_ovf", bus_t'(o_ovf), '0);
      idle(1);
      i_rst_n = 1'b1;
      idle(1);
      drive_beat(1'b0, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t6_acc_cleared", o_res, rep(16'h0100));
      idle(1);
      drive_beat(1'b1, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t6_single", o_res, rep(16'h0100));
      idle(4);
      chk("final_queue_empty", bus_t'(exp_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
